// File: rtl/carry_capture_pkg.sv
// Shared types and constants for the carry capture stage.
package carry_capture_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int BEAT_W   = 3;
   localparam int IDX_O0   = 0;
   localparam int IDX_O1   = 1;
   localparam int IDX_COUT = 2;

endpackage

// File: rtl/carry_sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module carry_sat_counter #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         CLR,
   input  logic         INC,
   output logic [W-1:0] CNT
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (INC && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign CNT = cnt_q;

endmodule

// File: rtl/carry_capture.sv
// Captures {COUT,O1,O0} beats into a 2-entry skid buffer (1-cycle latency, IN_READY low when FULL)
// and counts accepted COUT=1 beats; CARRY_CAPTURE_CIN_REG_EN adds the CIN_Q chaining flop.
module carry_capture
   import carry_capture_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic              O0,
   input  logic              O1,
   input  logic              COUT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [BEAT_W-1:0] OUT_DATA,
   input  logic              CNT_CLR,
`ifdef CARRY_CAPTURE_CIN_REG_EN
   output logic [CNT_W-1:0]  CARRY_CNT,
   output logic              CIN_Q
`else
   output logic [CNT_W-1:0]  CARRY_CNT
`endif
);

   state_t            state_d, state_q;
   logic [BEAT_W-1:0] head_d, head_q;
   logic [BEAT_W-1:0] skid_d, skid_q;
   logic              in_ready_d, in_ready_q;
   logic              out_valid_d, out_valid_q;
   logic [BEAT_W-1:0] in_beat;
   logic              accept;
   logic              pop;

   always_comb begin
      in_beat           = '0;
      in_beat[IDX_O0]   = O0;
      in_beat[IDX_O1]   = O1;
      in_beat[IDX_COUT] = COUT;
   end

   assign accept = IN_VALID & in_ready_q;
   assign pop    = out_valid_q & OUT_READY;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= EMPTY;
         head_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (accept) state_d = ONE;
         ONE: begin
            if (accept && !pop)      state_d = FULL;
            else if (pop && !accept) state_d = EMPTY;
         end
         FULL:    if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // Head is always the oldest beat; skid only fills when head is occupied and not leaving.
   always_comb begin
      head_d      = head_q;
      skid_d      = skid_q;
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
      unique case (state_q)
         EMPTY: if (accept) head_d = in_beat;
         ONE: begin
            if (accept && pop) head_d = in_beat;
            else if (accept)   skid_d = in_beat;
         end
         FULL:    if (pop) head_d = skid_q;
         default: head_d = head_q;
      endcase
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = head_q;

   carry_sat_counter #(
      .W(CNT_W)
   ) u_carry_cnt (
      .CLK  (CLK),
      .RST_N(RST_N),
      .CLR  (CNT_CLR),
      .INC  (accept & COUT),
      .CNT  (CARRY_CNT)
   );

`ifdef CARRY_CAPTURE_CIN_REG_EN
   logic cin_d, cin_q;

   assign cin_d = accept ? COUT : cin_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cin_q <= 1'b0;
      end else begin
         cin_q <= cin_d;
      end
   end

   assign CIN_Q = cin_q;
`endif

endmodule
